// File: rtl/alu_pkg.sv
// Shared ALU control codes and ALUOp class constants for the decoder and the ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_DIV = 3'b011,
        ALU_NOP = 3'b111
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ARITH = 2'b00;

    // Arithmetic op select maps straight onto the low code bits; everything else is NOP.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [1:0] op);
        return (aluop == ALUOP_ARITH) ? {1'b0, op} : ALU_NOP;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_decoder.sv
// ALU control decoder: combinational ALUControl plus a registered copy and decode statistics.
module alu_decoder
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [1:0]       op,
    input  logic             en,
    input  logic             clear,
    output logic [2:0]       ALUControl,
    output logic             is_arith,
    output logic [2:0]       ALUControl_r,
    output logic [CNT_W-1:0] arith_cnt,
    output logic [CNT_W-1:0] nop_cnt
);

    // Equality and ternary keep X/Z on the inputs visible on the outputs.
    assign is_arith   = (ALUOp == ALUOP_ARITH);
    assign ALUControl = alu_decode(ALUOp, op);

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUControl_r <= ALU_NOP;
        end else if (clear) begin
            ALUControl_r <= ALU_NOP;
        end else if (en) begin
            ALUControl_r <= ALUControl;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_arith_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (en & is_arith),
        .count (arith_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_nop_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (en & ~is_arith),
        .count (nop_cnt)
    );

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: default-width and 4-bit instances driven in parallel.
module tb_alu_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [1:0]  op = 2'b00;
    logic        en = 1'b0;
    logic        clear = 1'b0;

    logic [2:0]  ctl16, ctl4, ctlr16, ctlr4;
    logic        arith16, arith4;
    logic [15:0] acnt16, ncnt16;
    logic [3:0]  acnt4, ncnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_decoder dut16 (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .op(op), .en(en), .clear(clear),
        .ALUControl(ctl16), .is_arith(arith16), .ALUControl_r(ctlr16),
        .arith_cnt(acnt16), .nop_cnt(ncnt16)
    );

    alu_decoder #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .op(op), .en(en), .clear(clear),
        .ALUControl(ctl4), .is_arith(arith4), .ALUControl_r(ctlr4),
        .arith_cnt(acnt4), .nop_cnt(ncnt4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [2:0] r, input int a16, input int n16,
                              input int a4, input int n4);
        check({tag, "_r16"}, {29'd0, ctlr16}, {29'd0, r});
        check({tag, "_r4"},  {29'd0, ctlr4},  {29'd0, r});
        check({tag, "_a16"}, {16'd0, acnt16}, a16);
        check({tag, "_n16"}, {16'd0, ncnt16}, n16);
        check({tag, "_a4"},  {28'd0, acnt4},  a4);
        check({tag, "_n4"},  {28'd0, ncnt4},  n4);
    endtask

    logic [1:0] na_aluop [3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] na_op    [3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        // Combinational decode, arithmetic class
        for (int i = 0; i < 4; i++) begin
            ALUOp = 2'b00;
            op = i[1:0];
            #10;
            check("arith_ctl", {29'd0, ctl16}, i);
            check("arith_ctl4", {29'd0, ctl4}, i);
            check("arith_flag", {31'd0, arith16}, 1);
        end
        for (int i = 0; i < 3; i++) begin
            ALUOp = na_aluop[i];
            op = na_op[i];
            #10;
            check("nop_ctl", {29'd0, ctl16}, 32'h7);
            check("nop_flag", {31'd0, arith16}, 0);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_regs("reset", 3'b111, 0, 0, 0, 0);

        ALUOp = 2'b00; op = 2'b11; en = 1'b1;
        tick();
        check_regs("div_load", 3'b011, 1, 0, 1, 0);

        ALUOp = 2'b01; en = 1'b0;
        tick();
        check_regs("hold", 3'b011, 1, 0, 1, 0);

        // Reset raised between edges: registers untouched, decode stays live
        reset = 1'b1; ALUOp = 2'b00; op = 2'b10;
        #2;
        check_regs("mid_reset", 3'b011, 1, 0, 1, 0);
        check("live_ctl", {29'd0, ctl16}, 32'h2);
        check("live_flag", {31'd0, arith16}, 1);
        tick();
        reset = 1'b0;
        check_regs("reset2", 3'b111, 0, 0, 0, 0);

        ALUOp = 2'b10; op = 2'b01; en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_regs("nop_sat", 3'b111, 0, 20, 0, 15);

        ALUOp = 2'b00; op = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        check_regs("sub_x3", 3'b001, 3, 20, 3, 15);

        reset = 1'b1; clear = 1'b1;
        tick();
        reset = 1'b0; clear = 1'b0;
        check_regs("rst_clr_en", 3'b111, 0, 0, 0, 0);

        op = 2'b10;
        tick(); tick();
        check_regs("mul_x2", 3'b010, 2, 0, 2, 0);

        clear = 1'b1; op = 2'b01;
        tick();
        clear = 1'b0;
        check_regs("clear_en", 3'b111, 0, 0, 0, 0);

        ALUOp = 2'b11; op = 2'b00;
        tick();
        en = 1'b0;
        check_regs("post_clear", 3'b111, 0, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
